ka_uword_buf: RTL
=================

KA_UWORD_BUF -- requirements
Module: ka_uword_buf

Interface
REQ-001 SHALL provide parameters, one per line (name, default, meaning):
- UW_WIDTH, 96: micro-word width.
- NGRP, 4: parity group count.
- GRP_MASK, 384'h0, NGRP*UW_WIDTH membership bits; group g uses slice [g*UW_WIDTH +: UW_WIDTH].
- LIT_LSB, 40: index of the 2-bit LIT field in the micro-word.
- LIT_WIDTH, 32: long-literal width, taken from uop bits [LIT_WIDTH-1:0].
- CTR_W, 8: error counter width.
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports, one per line (name, direction, width, meaning):
- base_clock_h  in  1  sole clock, rising edge.
- sac_reset_h  in  1  synchronous active-high reset.
- cs_uop_h  in  UW_WIDTH  control-store micro-word.
- cs_par_h  in  NGRP  per-group parity bits.
- ld_en_h  in  1  load buffer (M-clock enable).
- stall_h  in  1  hold buffer (memory stall).
- par_chk_en_h  in  1  enable parity checking.
- litreg_ld_h  in  1  capture long literal.
- litr_en_l  in  1  drive literal onto R bus.
- clr_err_h  in  1  clear sticky error state.
- uop_h  out  UW_WIDTH  buffered micro-word.
- uop_vld_h  out  1  buffer holds a loaded word.
- long_lit_l  out  1  low when buffered LIT field == 2'b11.
- lit_rbus_l  out  LIT_WIDTH  wired-AND R-bus drive.
- par_err_h  out  1  registered parity error pulse.
- err_grp_h  out  NGRP  sticky failing-group vector.
- err_cnt_h  out  CTR_W  saturating error count.

Function
REQ-003 Buffer SHALL load cs_uop_h and cs_par_h on a clock edge with ld_en_h=1 and stall_h=0; otherwise it SHALL hold.
REQ-004 uop_vld_h SHALL set on the first load and remain set until reset.
REQ-005 long_lit_l SHALL be registered alongside the buffer as the NAND of incoming bits [LIT_LSB+1:LIT_LSB]; it SHALL hold when the buffer holds.
REQ-006 Group g fails when the XOR of (uop_h AND its mask) with the buffered parity bit g equals 0 (odd parity per group).
REQ-007 par_err_h SHALL assert for exactly one cycle, on the cycle after a load, when uop_vld_h=1, par_chk_en_h=1, and any group fails; a held word SHALL NOT re-flag.
REQ-008 On each par_err_h assertion, err_grp_h SHALL OR in the failing-group vector, and err_cnt_h SHALL increment, saturating at all-ones.
REQ-009 clr_err_h SHALL zero err_grp_h and err_cnt_h. If an error is registered in the same cycle, the new error SHALL win: err_grp_h = failing vector, err_cnt_h = 1.
REQ-010 The literal register SHALL load uop_h[LIT_WIDTH-1:0] when litreg_ld_h=1 and long_lit_l=0; otherwise it SHALL hold.
REQ-011 lit_rbus_l SHALL be all ones when litr_en_l=1, else the bitwise inverse of the literal register (combinational).
REQ-012 A load in the same cycle as litreg_ld_h SHALL capture the literal from the pre-load uop_h (latency 1).

Reset
REQ-013 On sac_reset_h=1, the following SHALL be set to these values:
- uop_h, buffered parity: 0
- uop_vld_h: 0
- long_lit_l: 1
- par_err_h: 0
- err_grp_h: 0
- err_cnt_h: 0
- literal register: 0 (so lit_rbus_l = all ones)
REQ-014 Reset SHALL override ld_en_h, clr_err_h and any pending error; no par_err_h SHALL follow reset.

Structure
REQ-015 A shared package SHALL hold the LIT field encoding constant (LIT_LONG = 2'b11) and the default GRP_MASK constant.
REQ-016 One sub-module, ka_par_grp (parameterised masked odd-parity checker for one group), SHALL be instantiated NGRP times via generate.

Verification
REQ-017 Reset with ld_en_h=1 -> uop_h=0, uop_vld_h=0, long_lit_l=1, lit_rbus_l=FFFFFFFF, no par_err_h.
REQ-018 Load a word with correct parity in all 4 groups, then stall_h=1 for 3 cycles with new inputs -> uop_h unchanged, par_err_h stays 0.
REQ-019 Load a word with group 2 parity flipped -> par_err_h=1 for one cycle, err_grp_h=4'b0100, err_cnt_h=1; hold 5 cycles -> count stays 1.
REQ-020 Load a word with LIT=2'b11 and low bits 32'h1234_5678, then litreg_ld_h=1 and litr_en_l=0 -> lit_rbus_l=32'hEDCB_A987; load LIT=2'b01 with litreg_ld_h=1 -> literal unchanged.
REQ-021 With CTR_W=2, inject 5 bad words -> err_cnt_h saturates at 3; then clr_err_h coinciding with a group-0 error -> err_grp_h=4'b0001, err_cnt_h=1.
REQ-022 Bad word with par_chk_en_h=0 -> no par_err_h; assert sac_reset_h mid-stall -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/ka_uword_buf_pkg.sv
// Shared constants for the micro-word buffer: LIT field encoding and the
// default parity-group membership mask.
package ka_uword_buf_pkg;

    // Width of the LIT field inside the micro-word.
    localparam int LIT_FIELD_W = 2;

    // LIT field encoding that marks a long literal in the low uop bits.
    localparam logic [LIT_FIELD_W-1:0] LIT_LONG = 2'b11;

    // Default membership mask for the default geometry (4 groups x 96 bits).
    // All-zero means no bit belongs to any group, so only the parity bit counts.
    localparam int                   KA_DFLT_UW_WIDTH = 96;
    localparam int                   KA_DFLT_NGRP     = 4;
    localparam logic [KA_DFLT_NGRP*KA_DFLT_UW_WIDTH-1:0] KA_GRP_MASK_DFLT = '0;

endpackage : ka_uword_buf_pkg

// File: rtl/ka_par_grp.sv
// Masked odd-parity checker for one parity group. The group covers the
// micro-word bits selected by MASK plus its own parity bit; the total number
// of ones must be odd, otherwise the group is flagged as failing.
module ka_par_grp #(
    parameter int             W    = 96,
    parameter logic [W-1:0]   MASK = '0
) (
    input  logic [W-1:0] uop_h,
    input  logic         par_h,
    output logic         fail_h
);

    logic masked_xor;

    // Reduce only the member bits of this group.
    assign masked_xor = ^(uop_h & MASK);

    // Even total (data members plus parity bit) is a failure.
    assign fail_h = ~(masked_xor ^ par_h);

endmodule : ka_par_grp

// File: rtl/ka_uword_buf.sv
// Control-store micro-word buffer. Captures the micro-word and its group
// parity on the M-clock enable, flags odd-parity violations one cycle after a
// load, keeps sticky error state with a saturating counter, and holds a long
// literal register that drives the wired-AND R bus (active low).
module ka_uword_buf
    import ka_uword_buf_pkg::*;
#(
    parameter int                           UW_WIDTH  = 96,
    parameter int                           NGRP      = 4,
    parameter logic [NGRP*UW_WIDTH-1:0]     GRP_MASK  = KA_GRP_MASK_DFLT,
    parameter int                           LIT_LSB   = 40,
    parameter int                           LIT_WIDTH = 32,
    parameter int                           CTR_W     = 8
) (
    input  logic                    base_clock_h,
    input  logic                    sac_reset_h,
    input  logic [UW_WIDTH-1:0]     cs_uop_h,
    input  logic [NGRP-1:0]         cs_par_h,
    input  logic                    ld_en_h,
    input  logic                    stall_h,
    input  logic                    par_chk_en_h,
    input  logic                    litreg_ld_h,
    input  logic                    litr_en_l,
    input  logic                    clr_err_h,
    output logic [UW_WIDTH-1:0]     uop_h,
    output logic                    uop_vld_h,
    output logic                    long_lit_l,
    output logic [LIT_WIDTH-1:0]    lit_rbus_l,
    output logic                    par_err_h,
    output logic [NGRP-1:0]         err_grp_h,
    output logic [CTR_W-1:0]        err_cnt_h
);

    localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

    logic [NGRP-1:0]        par_q;       // buffered group parity bits
    logic                   loaded_q;    // buffer was written on the last edge
    logic [LIT_WIDTH-1:0]   lit_q;       // long literal register
    logic [NGRP-1:0]        grp_fail;    // per-group failure on buffered word
    logic                   load;        // buffer write this edge
    logic                   err_now;     // error to register this edge
    logic                   long_next;   // active-low long-literal flag of incoming word
    logic [CTR_W-1:0]       cnt_inc;     // saturating increment of the counter

    // A stall freezes the buffer even when the M-clock enable is asserted.
    assign load = ld_en_h & ~stall_h;

    // NAND of the incoming LIT field: low only for the long-literal encoding.
    assign long_next = ~(cs_uop_h[LIT_LSB +: LIT_FIELD_W] == LIT_LONG);

    // Only a freshly loaded word is checked, so a held word never re-flags.
    assign err_now = loaded_q & uop_vld_h & par_chk_en_h & (|grp_fail);

    // Counter stops at all-ones instead of wrapping.
    assign cnt_inc = (&err_cnt_h) ? err_cnt_h : err_cnt_h + CTR_ONE;

    // One masked odd-parity checker per group, each with its own mask slice.
    for (genvar g = 0; g < NGRP; g++) begin : g_par
        ka_par_grp #(
            .W    (UW_WIDTH),
            .MASK (GRP_MASK[g*UW_WIDTH +: UW_WIDTH])
        ) u_par_grp (
            .uop_h  (uop_h),
            .par_h  (par_q[g]),
            .fail_h (grp_fail[g])
        );
    end

    // Micro-word buffer, parity, valid flag and long-literal flag.
    always_ff @(posedge base_clock_h) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (sac_reset_h) begin
            uop_h      <= '0;
            par_q      <= '0;
            uop_vld_h  <= 1'b0;
            long_lit_l <= 1'b1;
            loaded_q   <= 1'b0;
        end else begin
            loaded_q <= load;
            if (load) begin
                uop_h      <= cs_uop_h;
                par_q      <= cs_par_h;
                uop_vld_h  <= 1'b1;
                long_lit_l <= long_next;
            end
        end
    end

    // Parity error pulse, sticky failing-group vector and saturating count.
    always_ff @(posedge base_clock_h) begin
        if (sac_reset_h) begin
            par_err_h <= 1'b0;
            err_grp_h <= '0;
            err_cnt_h <= '0;
        end else begin
            par_err_h <= err_now;
            if (err_now) begin
                // A new error beats a simultaneous clear.
                if (clr_err_h) begin
                    err_grp_h <= grp_fail;
                    err_cnt_h <= CTR_ONE;
                end else begin
                    err_grp_h <= err_grp_h | grp_fail;
                    err_cnt_h <= cnt_inc;
                end
            end else if (clr_err_h) begin
                err_grp_h <= '0;
                err_cnt_h <= '0;
            end
        end
    end

    // Literal register captures the currently buffered word, not the one loading.
    always_ff @(posedge base_clock_h) begin
        if (sac_reset_h) begin
            lit_q <= '0;
        end else if (litreg_ld_h && !long_lit_l) begin
            lit_q <= uop_h[LIT_WIDTH-1:0];
        end
    end

    // Wired-AND R bus: released high unless the active-low enable is asserted.
    assign lit_rbus_l = litr_en_l ? '1 : ~lit_q;

endmodule : ka_uword_buf
